// File: rtl/buzz_pkg.sv
// Shared types and musical constants for the piezo note player.
package buzz_pkg;

    localparam int unsigned CLK_HZ = 100_000_000;

    typedef enum logic [1:0] {
        IDLE,
        PLAY,
        GAP
    } state_e;

    function automatic int unsigned note_hp(input int unsigned clk_hz, input int unsigned freq_hz);
        return clk_hz / (2 * freq_hz);
    endfunction

    // Half-periods in clock cycles, rounded down from the nearest integer Hz.
    localparam int unsigned HP_C4 = note_hp(CLK_HZ, 262);
    localparam int unsigned HP_D4 = note_hp(CLK_HZ, 294);
    localparam int unsigned HP_E4 = note_hp(CLK_HZ, 330);
    localparam int unsigned HP_F4 = note_hp(CLK_HZ, 349);
    localparam int unsigned HP_G4 = note_hp(CLK_HZ, 392);
    localparam int unsigned HP_A4 = note_hp(CLK_HZ, 440);
    localparam int unsigned HP_B4 = note_hp(CLK_HZ, 494);
    localparam int unsigned HP_C5 = note_hp(CLK_HZ, 523);
    localparam int unsigned HP_D5 = note_hp(CLK_HZ, 587);
    localparam int unsigned HP_E5 = note_hp(CLK_HZ, 659);
    localparam int unsigned HP_F5 = note_hp(CLK_HZ, 698);
    localparam int unsigned HP_G5 = note_hp(CLK_HZ, 784);
    localparam int unsigned HP_A5 = note_hp(CLK_HZ, 880);
    localparam int unsigned HP_B5 = note_hp(CLK_HZ, 988);

    localparam int unsigned DUR_WHOLE   = CLK_HZ;
    localparam int unsigned DUR_HALF    = CLK_HZ / 2;
    localparam int unsigned DUR_QUARTER = CLK_HZ / 4;
    localparam int unsigned DUR_EIGHTH  = CLK_HZ / 8;

endpackage

// File: rtl/buzz_tone_gen.sv
// Half-period divider: toggles the buzz phase every hp enabled cycles.
module buzz_tone_gen #(
    parameter int unsigned HP_W = 20
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en_i,
    input  logic            clr_i,
    input  logic [HP_W-1:0] hp_i,
    output logic            phase_nxt_o
);

    logic [HP_W-1:0] tone_cnt_q, tone_cnt_d;
    logic            phase_q, phase_d;

    always_comb begin
        tone_cnt_d = tone_cnt_q;
        phase_d    = phase_q;
        if (clr_i) begin
            tone_cnt_d = '0;
            phase_d    = 1'b0;
        end else if (en_i && hp_i != '0) begin
            if (tone_cnt_q == hp_i - HP_W'(1)) begin
                tone_cnt_d = '0;
                phase_d    = ~phase_q;
            end else begin
                tone_cnt_d = tone_cnt_q + HP_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tone_cnt_q <= '0;
            phase_q    <= 1'b0;
        end else begin
            tone_cnt_q <= tone_cnt_d;
            phase_q    <= phase_d;
        end
    end

    assign phase_nxt_o = phase_d;

endmodule

// File: rtl/buzz_note_player.sv
// Note playback stage: square-wave tone for a commanded duration, then a silent gap.
module buzz_note_player
    import buzz_pkg::*;
#(
    parameter int unsigned CLK_HZ     = 100_000_000,
    parameter int unsigned HP_W       = 20,
    parameter int unsigned DUR_W      = 28,
    parameter int unsigned GAP_CYCLES = 1_000_000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             note_valid,
    output logic             note_ready,
    input  logic [HP_W-1:0]  note_half_period,
    input  logic [DUR_W-1:0] note_duration,
    input  logic             pause,
    input  logic             abort,
    output logic             busy,
    output logic             note_done,
    output logic             buzz
);

    localparam int unsigned      GAP_W    = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1);

    if (longint'(note_hp(CLK_HZ, 262)) >= (longint'(1) << HP_W)) begin : g_hp_w_check
        $error("HP_W too narrow for the lowest package note at this CLK_HZ");
    end

    state_e             state_q, state_d;
    logic [HP_W-1:0]    hp_q, hp_d;
    logic [DUR_W-1:0]   dur_q, dur_d, dur_cnt_q, dur_cnt_d;
    logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
    logic               buzz_q, buzz_d, busy_q, busy_d, done_q, done_d;
    logic               accept, run, play_last, gap_last;
    logic               tone_en, tone_clr, phase_nxt;

    assign note_ready = (state_q == IDLE) && !abort;
    assign accept     = note_valid && note_ready;
    assign run        = !pause;
    assign play_last  = (state_q == PLAY) && run && (dur_cnt_q == dur_q - DUR_W'(1));
    assign gap_last   = (state_q == GAP) && run && (gap_cnt_q == GAP_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: if (accept && note_duration != '0) state_d = PLAY;
                PLAY: if (play_last) state_d = (GAP_CYCLES == 0) ? IDLE : GAP;
                GAP:  if (gap_last) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        hp_d      = hp_q;
        dur_d     = dur_q;
        dur_cnt_d = dur_cnt_q;
        gap_cnt_d = gap_cnt_q;
        done_d    = 1'b0;
        tone_en   = 1'b0;
        tone_clr  = 1'b0;
        if (abort) begin
            dur_cnt_d = '0;
            gap_cnt_d = '0;
            tone_clr  = 1'b1;
        end else begin
            unique case (state_q)
                IDLE: if (accept) begin
                    hp_d      = note_half_period;
                    dur_d     = note_duration;
                    dur_cnt_d = '0;
                    gap_cnt_d = '0;
                    tone_clr  = 1'b1;
                    done_d    = (note_duration == '0);
                end
                PLAY: if (run) begin
                    tone_en   = 1'b1;
                    dur_cnt_d = dur_cnt_q + DUR_W'(1);
                    if (play_last) begin
                        dur_cnt_d = '0;
                        tone_clr  = 1'b1;
                        done_d    = (GAP_CYCLES == 0);
                    end
                end
                GAP: if (run) begin
                    gap_cnt_d = gap_cnt_q + GAP_W'(1);
                    if (gap_last) begin
                        gap_cnt_d = '0;
                        done_d    = 1'b1;
                    end
                end
                default: ;
            endcase
        end
        // Pause silences the pin on the next edge while the tone phase is held.
        buzz_d = (state_d == PLAY && !pause) ? phase_nxt : 1'b0;
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hp_q      <= '0;
            dur_q     <= '0;
            dur_cnt_q <= '0;
            gap_cnt_q <= '0;
            buzz_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            hp_q      <= hp_d;
            dur_q     <= dur_d;
            dur_cnt_q <= dur_cnt_d;
            gap_cnt_q <= gap_cnt_d;
            buzz_q    <= buzz_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    buzz_tone_gen #(
        .HP_W (HP_W)
    ) u_tone (
        .clk         (clk),
        .rst_n       (rst_n),
        .en_i        (tone_en),
        .clr_i       (tone_clr),
        .hp_i        (hp_q),
        .phase_nxt_o (phase_nxt)
    );

    assign buzz      = buzz_q;
    assign busy      = busy_q;
    assign note_done = done_q;

endmodule

// File: doc/buzz_note_player.md
Name: buzz_note_player

Overview:
- Note-playback stage that drives the piezo buzzer pin directly.
- Accepts one note command at a time (half-period, duration) over a valid/ready handshake from the melody sequencer.
- Generates the square wave for that note, then inserts a fixed silent articulation gap and reports completion.
- Supports rests, pause (freeze) and abort.

Parameters:
- CLK_HZ, 100_000_000, system clock frequency; used only by package note constants.
- HP_W, 20, width of note_half_period (max 1_048_575 cycles, ~48 Hz minimum at 100 MHz).
- DUR_W, 28, width of note_duration (max ~2.68 s at 100 MHz).
- GAP_CYCLES, 1_000_000, silent cycles after every note (10 ms); 0 = no gap.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset
- note_valid  in  1  command valid
- note_ready  out  1  block can accept a command
- note_half_period  in  HP_W  clock cycles per buzz half-cycle; 0 = rest
- note_duration  in  DUR_W  note length in clock cycles
- pause  in  1  freeze playback, silence output
- abort  in  1  drop current note, return to IDLE
- busy  out  1  note in PLAY or GAP
- note_done  out  1  one-cycle pulse when a note (incl. gap) completes
- buzz  out  1  buzzer drive

Behaviour:
- Clock/reset: one clock; reset is asynchronous and active-low (clk, rst_n). All state is cleared at once on reset.
- Reset values: state=IDLE, buzz=0, busy=0, note_done=0, all counters and the phase register 0. note_ready=1 while in IDLE.
- States: IDLE, PLAY, GAP.
- note_ready = (state==IDLE) && !abort, combinational. A command is accepted on an edge where note_valid && note_ready; hp and dur are latched on that edge.
- Accept with dur==0: stay in IDLE, note_done=1 the next cycle, buzz stays 0.
- Accept with dur>0: go to PLAY. tone_cnt=0, dur_cnt=0, phase=0.
- PLAY, each unpaused cycle:
  - dur_cnt increments.
  - If hp!=0: tone_cnt increments. When tone_cnt==hp-1, tone_cnt resets to 0 and phase toggles.
  - Output period is 2*hp cycles. First rising edge of buzz occurs hp cycles after PLAY entry. hp==1 toggles every cycle.
  - hp==0 (rest): phase stays 0.
  - When dur_cnt==dur-1: go to GAP (or to IDLE with note_done if GAP_CYCLES==0) and phase is cleared. PLAY lasts exactly dur unpaused cycles.
- GAP: buzz=0; gap_cnt counts unpaused cycles. At GAP_CYCLES-1, go to IDLE and note_done=1 for one cycle.
- Back-to-back commands: a new command may be accepted in the same cycle note_done is high.
- buzz is registered: buzz <= phase_next when next state is PLAY and pause is low, else 0. While paused, buzz drops to 0 on the next edge and the phase register is preserved; buzz resumes the held phase on the first unpaused edge.
- pause in PLAY/GAP: all counters freeze; total note time extends by exactly the number of paused cycles. pause has no effect in IDLE; commands are still accepted.
- abort (synchronous, highest priority): next edge gives state=IDLE, buzz=0, counters cleared, no note_done. abort and note_valid in the same cycle: the command is not accepted.
- busy = (state!=IDLE), registered with the state.
- Counter widths: tone_cnt is HP_W, dur_cnt is DUR_W, gap_cnt is clog2(GAP_CYCLES+1). No wrap-around is possible because every compare is an equality against the latched value.
- Commands presented while busy are ignored: the upstream stage holds valid until ready.

Decomposition:
- Package buzz_pkg:
  - State enum (IDLE/PLAY/GAP).
  - Note half-period constants HP_C4..HP_B5 = CLK_HZ/(2*f) (e.g. HP_A4=113_636 at 100 MHz).
  - Duration constants WHOLE/HALF/QUARTER/EIGHTH.
- One sub-module, buzz_tone_gen: hp-divider with enable, clear and phase output. The FSM, duration and gap counters stay in the top module.

Test Plan (GAP_CYCLES=4 unless stated):
- Reset held mid-PLAY (hp=3, dur=12, rst_n low at PLAY cycle 5) -> buzz=0, busy=0, note_done=0 immediately; note_ready=1 after release.
- hp=3, dur=12 -> buzz low for 3 cycles, then high 3, low 3, high 3. busy high for 16 cycles. note_done pulses 16 cycles after the accept edge. Second command accepted in the note_done cycle.
- Rest hp=0, dur=10 -> buzz constant 0, note_done 14 cycles after accept. dur=0 -> note_done the next cycle, busy never rises.
- hp=3, dur=12, pause high for 5 cycles starting at PLAY cycle 4 -> buzz 0 during pause, phase resumes high after release, note_done at cycle 21.
- abort at PLAY cycle 6 -> next cycle IDLE, buzz=0, no note_done. abort held with note_valid in IDLE -> no accept.
- GAP_CYCLES=0, hp=1, dur=4 -> buzz toggles every cycle (1,0,1,0 after a 1-cycle lead), note_done 4 cycles after accept.
